// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the ALU and load-return channels onto the single
// register-file write port, tracks loads still in flight and exposes a bypass.
module wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_val,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_val,
  output logic            ld_ready,
  input  logic            iss_mark,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rs1_fwd,
  output logic            rs2_fwd,
  output logic [XLEN-1:0] fwd_val,
  output logic [4:0]      rd,
  output logic            rd_write_control,
  output logic [XLEN-1:0] rd_write_val
);

  logic [1:0]      alu_skip;
  logic [1:0]      alu_skip_next;
  logic [31:0]     pending;
  logic [31:0]     pending_next;
  logic            skip_max;
  logic            alu_fire;
  logic            ld_fire;
  logic            wr_fire;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_val;

  // Loads win ties until the ALU has been passed over twice in a row.
  assign skip_max  = (alu_skip == 2'd2);
  assign ld_ready  = ~(alu_valid & skip_max);
  assign alu_ready = ~ld_valid | skip_max;
  assign alu_fire  = alu_valid & alu_ready;
  assign ld_fire   = ld_valid & ld_ready;
  assign wr_fire   = alu_fire | ld_fire;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    alu_skip_next = 2'd0;
    if (alu_valid && ld_valid && !skip_max) alu_skip_next = alu_skip + 2'd1;
  end

  always_comb begin
    wr_rd  = ld_rd;
    wr_val = ld_val;
    if (alu_fire) begin
      wr_rd  = alu_rd;
      wr_val = alu_val;
    end
  end

  // Clear on load return first, then set, so a same-edge re-issue keeps the bit.
  always_comb begin
    pending_next = pending;
    if (ld_fire) pending_next[ld_rd] = 1'b0;
    if (iss_mark && (iss_rd != 5'd0)) pending_next[iss_rd] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignment; always_comb uses blocking.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      alu_skip         <= 2'd0;
      pending          <= '0;
      rd               <= 5'd0;
      rd_write_control <= 1'b0;
      rd_write_val     <= '0;
    end else begin
      alu_skip         <= alu_skip_next;
      pending          <= pending_next;
      rd_write_control <= wr_fire & (wr_rd != 5'd0);
      if (wr_fire) begin
        rd           <= wr_rd;
        rd_write_val <= wr_val;
      end
    end
  end

  assign rs1_busy = (rs1 != 5'd0) & pending[rs1];
  assign rs2_busy = (rs2 != 5'd0) & pending[rs2];
  assign rs1_fwd  = rd_write_control & (rd == rs1) & (rs1 != 5'd0);
  assign rs2_fwd  = rd_write_control & (rd == rs2) & (rs2 != 5'd0);
  assign fwd_val  = rd_write_val;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a per-cycle scoreboard against a transaction-level model
// plus directed scenarios with literal expectations.
module tb_wb_arbiter;
  localparam int XLEN = 32;

  typedef enum int {G_NONE, G_ALU, G_LD} grant_e;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            alu_valid, ld_valid, iss_mark;
  logic [4:0]      alu_rd, ld_rd, iss_rd, rs1, rs2;
  logic [XLEN-1:0] alu_val, ld_val;
  logic            alu_ready, ld_ready, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd;
  logic [XLEN-1:0] fwd_val, rd_write_val;
  logic [4:0]      rd;
  logic            rd_write_control;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  wb_arbiter #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_val(alu_val), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_val(ld_val), .ld_ready(ld_ready),
    .iss_mark(iss_mark), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_val(fwd_val),
    .rd(rd), .rd_write_control(rd_write_control), .rd_write_val(rd_write_val)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: who gets the write port, by the priority rules.
  function automatic grant_e grant(bit a, bit l, int skip);
    if (a && l) return (skip < 2) ? G_LD : G_ALU;
    if (a) return G_ALU;
    if (l) return G_LD;
    return G_NONE;
  endfunction

  int        m_skip = 0;
  bit [31:0] m_pend = '0;
  bit [4:0]  m_rd   = '0;
  bit [31:0] m_val  = '0;
  bit        m_ctrl = 1'b0;

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      m_skip = 0; m_pend = '0; m_rd = '0; m_val = '0; m_ctrl = 1'b0;
    end else begin
      grant_e g;
      g = grant(alu_valid, ld_valid, m_skip);
      m_skip = (alu_valid && ld_valid && m_skip < 2) ? m_skip + 1 : 0;
      m_ctrl = 1'b0;
      if (g == G_ALU) begin
        m_rd = alu_rd; m_val = alu_val; m_ctrl = (alu_rd != 0);
      end else if (g == G_LD) begin
        m_rd = ld_rd; m_val = ld_val; m_ctrl = (ld_rd != 0);
        m_pend[ld_rd] = 1'b0;
      end
      if (iss_mark && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    end
  end

  // A channel is ready exactly when it would be granted if it were asking.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("sb_alu_ready", alu_ready, grant(1'b1, ld_valid, m_skip) == G_ALU);
      check("sb_ld_ready", ld_ready, grant(alu_valid, 1'b1, m_skip) == G_LD);
      check("sb_wr_ctrl", rd_write_control, m_ctrl);
      check("sb_rd", rd, m_rd);
      check("sb_wr_val", rd_write_val, m_val);
      check("sb_fwd_val", fwd_val, m_val);
      check("sb_rs1_busy", rs1_busy, (rs1 != 0) && m_pend[rs1]);
      check("sb_rs2_busy", rs2_busy, (rs2 != 0) && m_pend[rs2]);
      check("sb_rs1_fwd", rs1_fwd, m_ctrl && (m_rd == rs1) && (rs1 != 0));
      check("sb_rs2_fwd", rs2_fwd, m_ctrl && (m_rd == rs2) && (rs2 != 0));
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    bit [3:0] exp_ld_rdy;
    logic [4:0] exp_rd [4];
    exp_ld_rdy = 4'b1011;  // bit i = ld_ready in cycle i (cycle 0 is LSB)
    exp_rd[0] = 5'd4; exp_rd[1] = 5'd4; exp_rd[2] = 5'd3; exp_rd[3] = 5'd4;

    i_rst = 1'b0;
    alu_valid = 0; ld_valid = 0; iss_mark = 0;
    alu_rd = 0; ld_rd = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    alu_val = 0; ld_val = 0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_en = 1'b1;
    check("rst_ctrl", rd_write_control, 0);
    check("rst_rd", rd, 0);
    check("rst_val", rd_write_val, 0);
    i_rst = 1'b1;
    cyc();

    // Single ALU write
    alu_valid = 1; alu_rd = 5; alu_val = 32'h1234;
    #1 check("s1_alu_ready", alu_ready, 1);
    cyc();
    alu_valid = 0;
    #1;
    check("s1_rd", rd, 5);
    check("s1_ctrl", rd_write_control, 1);
    check("s1_val", rd_write_val, 32'h1234);
    cyc();
    #1;
    check("s1_ctrl_drop", rd_write_control, 0);
    check("s1_rd_hold", rd, 5);

    // Contention: ld, ld, alu, ld
    alu_valid = 1; alu_rd = 3; alu_val = 32'hA;
    ld_valid = 1; ld_rd = 4; ld_val = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("s2_ld_ready", ld_ready, exp_ld_rdy[i]);
      check("s2_alu_ready", alu_ready, !exp_ld_rdy[i]);
      if (i > 0) check("s2_order", rd, exp_rd[i-1]);
      cyc();
    end
    alu_valid = 0; ld_valid = 0;
    #1 check("s2_order_last", rd, exp_rd[3]);
    cyc();

    // Pending set by issue, cleared by load return, bypassed
    iss_mark = 1; iss_rd = 7; rs1 = 7;
    #1 check("s3_busy_pre", rs1_busy, 0);
    cyc();
    iss_mark = 0;
    #1 check("s3_busy", rs1_busy, 1);
    ld_valid = 1; ld_rd = 7; ld_val = 32'hBEEF;
    #1 check("s3_ld_ready", ld_ready, 1);
    cyc();
    ld_valid = 0;
    #1;
    check("s3_busy_clr", rs1_busy, 0);
    check("s3_fwd", rs1_fwd, 1);
    check("s3_fwd_val", fwd_val, 32'hBEEF);
    cyc();

    // Set wins over same-edge clear
    iss_mark = 1; iss_rd = 9; ld_valid = 1; ld_rd = 9; ld_val = 32'h99; rs2 = 9;
    cyc();
    iss_mark = 0; ld_valid = 0;
    #1;
    check("s4_busy", rs2_busy, 1);
    check("s4_fwd", rs2_fwd, 1);
    cyc();
    ld_valid = 1;
    cyc();
    ld_valid = 0;
    #1 check("s4_busy_clr", rs2_busy, 0);

    // Writes and marks to x0
    alu_valid = 1; alu_rd = 0; alu_val = 32'h55; iss_mark = 1; iss_rd = 0; rs1 = 0;
    #1 check("s5_alu_ready", alu_ready, 1);
    cyc();
    alu_valid = 0; iss_mark = 0;
    #1;
    check("s5_ctrl", rd_write_control, 0);
    check("s5_val", rd_write_val, 32'h55);
    check("s5_busy", rs1_busy, 0);
    check("s5_fwd", rs1_fwd, 0);
    cyc();

    // Reset in the middle of a write
    iss_mark = 1; iss_rd = 20; rs2 = 20;
    cyc();
    iss_mark = 0;
    alu_valid = 1; alu_rd = 3; alu_val = 32'hA;
    ld_valid = 1; ld_rd = 12; ld_val = 32'h77;
    #1 check("s6_busy", rs2_busy, 1);
    cyc();
    cyc();
    #1 check("s6_ctrl_pre", rd_write_control, 1);
    i_rst = 1'b0;
    #1;
    check("s6_ctrl", rd_write_control, 0);
    check("s6_rd", rd, 0);
    check("s6_val", rd_write_val, 0);
    check("s6_pend", rs2_busy, 0);
    check("s6_skip_alu", alu_ready, 0);
    check("s6_skip_ld", ld_ready, 1);
    #1 i_rst = 1'b1;
    cyc();
    #1;
    check("s6_resume_rd", rd, 12);
    check("s6_resume_ctrl", rd_write_control, 1);
    cyc();
    #1 check("s6_resume_alu", alu_ready, 1);
    alu_valid = 0; ld_valid = 0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
